push_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the 16-bit stack processor's push/pop path.
- Accepts one stack operation at a time from the main control unit over a valid/ready handshake.
- Drives the push subsystem's select and strobe lines (PushSrc, ShiftSrc, ShamtSrc, RegWrite), plus MemWrite for spills.
- Owns the stack pointer and depth counter, and flags overflow/underflow.

---
 rtl/push_seq_ctrl_pkg.sv | 35 +++
 rtl/push_seq_ctrl_if.sv | 38 +++
 rtl/push_seq_ctrl_sp_depth_counter.sv | 55 +++++
 rtl/push_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_push_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/push_seq_ctrl_pkg.sv
// Shared encodings for the stack processor push/pop sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package push_seq_ctrl_pkg;

  // Stack operation codes as issued by the main control unit
  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_DUP  = 2'b10,
    OP_NOP  = 2'b11
  } op_kind_e;

  // Push mux select encodings
  localparam logic [2:0] PSRC_ALU   = 3'b000;
  localparam logic [2:0] PSRC_B     = 3'b001;
  localparam logic [2:0] PSRC_SHIFT = 3'b010;
  localparam logic [2:0] PSRC_MEM   = 3'b011;
  localparam logic [2:0] PSRC_REGF  = 3'b100;
  localparam logic [2:0] PSRC_SE    = 3'b101;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    SHIFT = 3'd2,
    WRITE = 3'd3,
    POPRD = 3'd4,
    ERR   = 3'd5
  } state_e;

  // Bytes per stack entry; the stack grows downward
  localparam logic [15:0] SP_STEP = 16'd2;

endpackage

// File: rtl/push_seq_ctrl_if.sv
// Control-unit <-> push sequencer bundle: op request handshake and push-path controls.
// Latency: n/a (wires only).
// Backpressure: op_ready low holds the control unit's request.
interface push_seq_ctrl_if #(
  parameter int DEPTH_W = 8
);
  logic               op_valid;
  logic               op_ready;
  logic [1:0]         op_kind;
  logic [2:0]         op_src;
  logic               op_shift;
  logic               op_shamt_imm;
  logic               clr_err;
  logic [2:0]         PushSrc;
  logic               ShiftSrc;
  logic               ShamtSrc;
  logic               RegWrite;
  logic               MemWrite;
  logic [15:0]        sp;
  logic [DEPTH_W:0]   depth;
  logic               done;
  logic               ovf;
  logic               unf;

  // Control unit side
  modport master (
    output op_valid, op_kind, op_src, op_shift, op_shamt_imm, clr_err,
    input  op_ready, PushSrc, ShiftSrc, ShamtSrc, RegWrite, MemWrite,
    input  sp, depth, done, ovf, unf
  );

  // Sequencer side
  modport slave (
    input  op_valid, op_kind, op_src, op_shift, op_shamt_imm, clr_err,
    output op_ready, PushSrc, ShiftSrc, ShamtSrc, RegWrite, MemWrite,
    output sp, depth, done, ovf, unf
  );
endinterface

// File: rtl/push_seq_ctrl_sp_depth_counter.sv
// Stack pointer and entry-count registers with full/empty status.
// Latency: inc/dec take effect at the next rising edge; full/empty are combinational.
// Backpressure: none; the caller must not request inc when full or dec when empty.
module push_seq_ctrl_sp_depth_counter
  import push_seq_ctrl_pkg::*;
#(
  parameter int          DEPTH_W = 8,
  parameter logic [15:0] SP_BASE = 16'hFFFE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [15:0]      sp_o,
  output logic [DEPTH_W:0] depth_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [DEPTH_W:0] MAX_DEPTH = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic [DEPTH_W:0] ONE       = (DEPTH_W+1)'(1);

  logic [15:0]      sp_q, sp_d;
  logic [DEPTH_W:0] depth_q, depth_d;

  // Push moves sp down one entry, pop moves it back up
  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    if (inc_i) begin
      sp_d    = sp_q - SP_STEP;
      depth_d = depth_q + ONE;
    end else if (dec_i) begin
      sp_d    = sp_q + SP_STEP;
      depth_d = depth_q - ONE;
    end
  end

  // Register update; reset returns to the empty stack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q    <= SP_BASE;
      depth_q <= '0;
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
    end
  end

  assign sp_o    = sp_q;
  assign depth_o = depth_q;
  assign full_o  = (depth_q == MAX_DEPTH);
  assign empty_o = (depth_q == '0);

endmodule

// File: rtl/push_seq_ctrl.sv
// Multi-cycle push/pop sequencer: drives push-path selects/strobes, owns sp/depth, flags errors.
// Latency: accept->done 2 cycles (push/dup/pop), 3 with shift, 1 for errors and reserved ops.
// Backpressure: op_ready is high only in IDLE; one operation in flight at a time.
module push_seq_ctrl
  import push_seq_ctrl_pkg::*;
#(
  parameter int          DEPTH_W = 8,
  parameter logic [15:0] SP_BASE = 16'hFFFE
) (
  input  logic           clk,
  input  logic           reset,
  push_seq_ctrl_if.slave bus
);

  state_e   state_q, state_d;
  op_kind_e kind_q, kind_d, kind_in;
  logic [2:0] src_q, src_d;
  logic     shift_q, shift_d;
  logic     shamt_q, shamt_d;
  logic     err_ovf_q, err_ovf_d;   // 1: ERR is an overflow, 0: underflow
  logic     ovf_q, unf_q;

  logic       ready, done, reg_wr, mem_wr, shift_src, shamt_src, inc, dec;
  logic [2:0] push_src;
  logic       full, empty;

  assign kind_in = op_kind_e'(bus.op_kind);

  // Next state, operand capture on acceptance, and per-state push-path controls
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    src_d     = src_q;
    shift_d   = shift_q;
    shamt_d   = shamt_q;
    err_ovf_d = err_ovf_q;
    ready     = 1'b0;
    done      = 1'b0;
    reg_wr    = 1'b0;
    mem_wr    = 1'b0;
    shift_src = 1'b0;
    shamt_src = 1'b0;
    push_src  = PSRC_ALU;
    inc       = 1'b0;
    dec       = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.op_valid) begin
          kind_d  = kind_in;
          src_d   = (kind_in == OP_DUP) ? PSRC_REGF : bus.op_src;
          shift_d = bus.op_shift;
          shamt_d = bus.op_shamt_imm;
          case (kind_in)
            OP_PUSH: begin
              err_ovf_d = 1'b1;
              state_d   = full ? ERR : SEL;
            end
            // DUP reads the top entry and adds one, so it can fail either way
            OP_DUP: begin
              err_ovf_d = !empty;
              state_d   = (empty || full) ? ERR : SEL;
            end
            OP_POP: begin
              err_ovf_d = 1'b0;
              state_d   = empty ? ERR : POPRD;
            end
            default: state_d = WRITE;
          endcase
        end
      end
      SEL: begin
        push_src = src_q;
        state_d  = shift_q ? SHIFT : WRITE;
      end
      SHIFT: begin
        push_src  = PSRC_SHIFT;
        shift_src = 1'b1;
        shamt_src = shamt_q;
        state_d   = WRITE;
      end
      POPRD: begin
        push_src = PSRC_MEM;
        state_d  = WRITE;
      end
      WRITE: begin
        done    = 1'b1;
        state_d = IDLE;
        case (kind_q)
          OP_PUSH, OP_DUP: begin
            push_src  = shift_q ? PSRC_SHIFT : src_q;
            shift_src = shift_q;
            shamt_src = shift_q & shamt_q;
            reg_wr    = 1'b1;
            mem_wr    = 1'b1;
            inc       = 1'b1;
          end
          OP_POP: begin
            push_src = PSRC_MEM;
            reg_wr   = 1'b1;
            dec      = 1'b1;
          end
          default: ;
        endcase
      end
      ERR: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured operation fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      kind_q    <= OP_NOP;
      src_q     <= PSRC_ALU;
      shift_q   <= 1'b0;
      shamt_q   <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      src_q     <= src_d;
      shift_q   <= shift_d;
      shamt_q   <= shamt_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  // Sticky error flags; a set in ERR beats a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ((state_q == ERR) &&  err_ovf_q) || (ovf_q && !bus.clr_err);
      unf_q <= ((state_q == ERR) && !err_ovf_q) || (unf_q && !bus.clr_err);
    end
  end

  push_seq_ctrl_sp_depth_counter #(
    .DEPTH_W (DEPTH_W),
    .SP_BASE (SP_BASE)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (inc),
    .dec_i   (dec),
    .sp_o    (bus.sp),
    .depth_o (bus.depth),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.op_ready = ready;
  assign bus.done     = done;
  assign bus.RegWrite = reg_wr;
  assign bus.MemWrite = mem_wr;
  assign bus.ShiftSrc = shift_src;
  assign bus.ShamtSrc = shamt_src;
  assign bus.PushSrc  = push_src;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;

endmodule

// File: tb/tb_push_seq_ctrl.sv
// Testbench for push_seq_ctrl with a small stack (DEPTH_W=2) so both boundaries are reached often.
// Reference model: entry count plus sticky flags; sp derived as base - 2*count.
// Each task drives one scenario and compares DUT outputs against the model inline.
module tb_push_seq_ctrl;

  localparam int DW   = 2;
  localparam int MAXD = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  int   m_depth;
  logic m_ovf, m_unf;

  push_seq_ctrl_if #(.DEPTH_W(DW)) bus ();

  push_seq_ctrl #(.DEPTH_W(DW), .SP_BASE(16'hFFFE)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_sp(input int d);
    return 16'hFFFE - 16'(2 * d);
  endfunction

  task automatic idle_inputs();
    bus.op_valid     = 1'b0;
    bus.op_kind      = 2'b00;
    bus.op_src       = 3'b000;
    bus.op_shift     = 1'b0;
    bus.op_shamt_imm = 1'b0;
    bus.clr_err      = 1'b0;
  endtask

  // Compare sp/depth/flags/ready against the model while idle
  task automatic check_idle(input string tag);
    checks++;
    if (bus.sp !== exp_sp(m_depth)) begin
      failures++; $display("FAIL %s sp: got %h expected %h", tag, bus.sp, exp_sp(m_depth));
    end
    checks++;
    if (bus.depth !== (DW+1)'(m_depth)) begin
      failures++; $display("FAIL %s depth: got %0d expected %0d", tag, bus.depth, m_depth);
    end
    checks++;
    if (bus.ovf !== m_ovf) begin
      failures++; $display("FAIL %s ovf: got %b expected %b", tag, bus.ovf, m_ovf);
    end
    checks++;
    if (bus.unf !== m_unf) begin
      failures++; $display("FAIL %s unf: got %b expected %b", tag, bus.unf, m_unf);
    end
    checks++;
    if (bus.op_ready !== 1'b1) begin
      failures++; $display("FAIL %s op_ready: got %b expected 1", tag, bus.op_ready);
    end
  endtask

  // Issue one operation, trace it to completion and check it against the model
  task automatic exec_op(input logic [1:0] k, input logic [2:0] s, input logic sh,
                         input logic im, input string tag);
    bit         is_push, is_pop, is_nop, err_o, err_u, ok;
    int         exp_lat, got_lat, w;
    logic       exp_rw, exp_mw, got_rw, got_mw, early;
    logic [2:0] exp_sel, exp_wsrc, got_sel, got_wsrc, sh_psrc;
    logic       sh_ss, sh_sa;
    is_push = (k == 2'b00) || (k == 2'b10);
    is_pop  = (k == 2'b01);
    is_nop  = (k == 2'b11);
    err_u   = ((k == 2'b01) || (k == 2'b10)) && (m_depth == 0);
    err_o   = is_push && !err_u && (m_depth == MAXD);
    ok      = !err_o && !err_u && !is_nop;
    exp_sel = (k == 2'b10) ? 3'b100 : (is_pop ? 3'b011 : s);
    exp_wsrc = is_pop ? 3'b011 : (sh ? 3'b010 : exp_sel);
    if (!ok)        begin exp_lat = 1; exp_rw = 1'b0; exp_mw = 1'b0; end
    else if (is_pop) begin exp_lat = 2; exp_rw = 1'b1; exp_mw = 1'b0; end
    else            begin exp_lat = sh ? 3 : 2; exp_rw = 1'b1; exp_mw = 1'b1; end

    w = 0;
    while (!bus.op_ready && w < 10) begin @(negedge clk); w++; end
    bus.op_valid = 1'b1; bus.op_kind = k; bus.op_src = s;
    bus.op_shift = sh; bus.op_shamt_imm = im;
    @(posedge clk);
    #1;
    // Scramble fields after acceptance; the sequencer must use its captured copy
    bus.op_valid = 1'b0;
    bus.op_kind  = 2'($urandom); bus.op_src = 3'($urandom);
    bus.op_shift = 1'($urandom); bus.op_shamt_imm = 1'($urandom);

    got_lat = 0; got_rw = 1'b0; got_mw = 1'b0; early = 1'b0;
    got_sel = 3'b000; got_wsrc = 3'b000; sh_psrc = 3'b000; sh_ss = 1'b0; sh_sa = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) got_sel = bus.PushSrc;
      if (c == 2) begin sh_psrc = bus.PushSrc; sh_ss = bus.ShiftSrc; sh_sa = bus.ShamtSrc; end
      if (bus.done === 1'b1) begin
        got_lat = c; got_rw = bus.RegWrite; got_mw = bus.MemWrite; got_wsrc = bus.PushSrc;
        break;
      end
      if (bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0) early = 1'b1;
    end

    checks++;
    if (got_lat !== exp_lat) begin
      failures++; $display("FAIL %s latency: got %0d expected %0d", tag, got_lat, exp_lat);
    end
    checks++;
    if (got_rw !== exp_rw || got_mw !== exp_mw) begin
      failures++; $display("FAIL %s strobes: got RegWrite=%b MemWrite=%b expected %b %b",
                           tag, got_rw, got_mw, exp_rw, exp_mw);
    end
    checks++;
    if (early !== 1'b0) begin
      failures++; $display("FAIL %s early_strobe: got 1 expected 0", tag);
    end
    if (ok) begin
      checks++;
      if (got_sel !== exp_sel) begin
        failures++; $display("FAIL %s first_cycle_PushSrc: got %b expected %b", tag, got_sel, exp_sel);
      end
      checks++;
      if (got_wsrc !== exp_wsrc) begin
        failures++; $display("FAIL %s write_PushSrc: got %b expected %b", tag, got_wsrc, exp_wsrc);
      end
      if (is_push && sh) begin
        checks++;
        if (sh_psrc !== 3'b010 || sh_ss !== 1'b1 || sh_sa !== im) begin
          failures++; $display("FAIL %s shift_cycle: got PushSrc=%b ShiftSrc=%b ShamtSrc=%b expected 010 1 %b",
                               tag, sh_psrc, sh_ss, sh_sa, im);
        end
      end
    end

    if (err_o) m_ovf = 1'b1;
    if (err_u) m_unf = 1'b1;
    if (ok && is_push) m_depth++;
    if (ok && is_pop)  m_depth--;
    @(negedge clk);
    check_idle(tag);
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_err = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0 || bus.done !== 1'b0 ||
        bus.ShiftSrc !== 1'b0 || bus.ShamtSrc !== 1'b0 || bus.PushSrc !== 3'b000) begin
      failures++; $display("FAIL reset_outputs: got RW=%b MW=%b done=%b SS=%b SA=%b PS=%b expected all 0",
                           bus.RegWrite, bus.MemWrite, bus.done, bus.ShiftSrc, bus.ShamtSrc, bus.PushSrc);
    end
    check_idle("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset_released");
  endtask

  task automatic test_push_basic();
    exec_op(2'b00, 3'b000, 1'b0, 1'b0, "push_alu");
    checks++;
    if (bus.sp !== 16'hFFFC) begin
      failures++; $display("FAIL push_alu_sp_abs: got %h expected FFFC", bus.sp);
    end
  endtask

  task automatic test_push_shift();
    exec_op(2'b00, 3'b001, 1'b1, 1'b1, "push_shift_imm");
  endtask

  task automatic test_pop();
    exec_op(2'b01, 3'b000, 1'b0, 1'b0, "pop_1");
    exec_op(2'b01, 3'b000, 1'b0, 1'b0, "pop_2");
    checks++;
    if (bus.sp !== 16'hFFFE || bus.depth !== 3'd0) begin
      failures++; $display("FAIL pop_back_to_base: got sp=%h depth=%0d expected FFFE 0", bus.sp, bus.depth);
    end
  endtask

  task automatic test_underflow_clr();
    exec_op(2'b01, 3'b000, 1'b0, 1'b0, "pop_empty");
    exec_op(2'b10, 3'b000, 1'b0, 1'b0, "dup_empty");
    pulse_clr();
    checks++;
    if (bus.unf !== 1'b0) begin
      failures++; $display("FAIL clr_err_unf: got %b expected 0", bus.unf);
    end
  endtask

  // clr_err held across the ERR edge: the new underflow must survive
  task automatic test_set_wins();
    bus.op_valid = 1'b1; bus.op_kind = 2'b01; bus.clr_err = 1'b1;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.clr_err = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b1;
    @(negedge clk);
    check_idle("set_wins");
  endtask

  task automatic test_nop();
    exec_op(2'b00, 3'b101, 1'b0, 1'b0, "push_se");
    exec_op(2'b11, 3'b011, 1'b1, 1'b1, "reserved_nop");
    exec_op(2'b01, 3'b000, 1'b0, 1'b0, "pop_after_nop");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) exec_op(2'b00, 3'(i), 1'b0, 1'b0, "fill_push");
    checks++;
    if (bus.sp !== 16'hFFF6 || bus.depth !== 3'd4 || bus.ovf !== 1'b0) begin
      failures++; $display("FAIL fill_last_slot: got sp=%h depth=%0d ovf=%b expected FFF6 4 0",
                           bus.sp, bus.depth, bus.ovf);
    end
    exec_op(2'b00, 3'b000, 1'b0, 1'b0, "push_full");
    checks++;
    if (bus.sp !== 16'hFFF6 || bus.ovf !== 1'b1) begin
      failures++; $display("FAIL overflow: got sp=%h ovf=%b expected FFF6 1", bus.sp, bus.ovf);
    end
  endtask

  task automatic test_reset_mid();
    exec_op(2'b01, 3'b000, 1'b0, 1'b0, "pop_before_reset");
    bus.op_valid = 1'b1; bus.op_kind = 2'b00; bus.op_src = 3'b000;
    bus.op_shift = 1'b1; bus.op_shamt_imm = 1'b1;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ShiftSrc !== 1'b1) begin
      failures++; $display("FAIL reset_mid_in_shift: got ShiftSrc=%b expected 1", bus.ShiftSrc);
    end
    rst_n = 1'b0;
    #1;
    m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0 || bus.ShiftSrc !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_mid_strobes: got RW=%b MW=%b SS=%b done=%b expected 0",
                           bus.RegWrite, bus.MemWrite, bus.ShiftSrc, bus.done);
    end
    check_idle("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("after_reset_mid");
  endtask

  task automatic test_random();
    logic [1:0] k;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) pulse_clr();
      k = 2'($urandom_range(0, 3));
      exec_op(k, 3'($urandom_range(0, 5)), 1'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_push_basic();
    test_push_shift();
    test_pop();
    test_underflow_clr();
    test_set_wins();
    test_nop();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
